// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin AXI-Stream arbiter holding each grant for one packet; optional stall timeout under AXIS_ARB_TIMEOUT_EN
module axis_rr_arbiter #(
    parameter int TDATA_WIDTH    = 512,
    parameter int NUM_SRC        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW            = $clog2(NUM_SRC)
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NUM_SRC-1:0]             s_tvalid,
    input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]             s_tlast,
    output logic [NUM_SRC-1:0]             s_tready,
    output logic                           m_tvalid,
    output logic [TDATA_WIDTH-1:0]         m_tdata,
    output logic                           m_tlast,
    input  logic                           m_tready,
    output logic [IW-1:0]                  grant_idx,
    output logic                           busy,
    output logic                           timeout_err
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t r_state;
    state_t w_next;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] w_sel;
    logic [IW-1:0] w_idx;
    logic [TDATA_WIDTH-1:0] w_slice [NUM_SRC];
    logic w_hs;
    logic w_force;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
        assign w_slice[i] = s_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
    end
    assign w_hs      = m_tvalid & m_tready;
    assign grant_idx = r_grant;
    assign busy      = r_state == LOCKED;
    // search ptr+1, ptr+2, ... so the nearest valid source after the last winner is chosen
    always_comb begin
        w_sel = r_ptr;
        w_idx = r_ptr;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_idx = IW'((32'(r_ptr) + 32'(k)) % NUM_SRC);
            if (s_tvalid[w_idx]) w_sel = w_idx;
        end
    end
    // state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else r_state <= w_next;
    end
    // leave LOCKED on the tlast handshake or a forced release
    always_comb begin
        w_next = (r_state == IDLE) ? (|s_tvalid ? LOCKED : IDLE)
                                   : (((w_hs && m_tlast) || w_force) ? IDLE : LOCKED);
    end
    // capture the winner as both the grant and the new priority pointer
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ptr   <= IW'(NUM_SRC - 1);
            r_grant <= '0;
        end else if (r_state == IDLE && |s_tvalid) begin
            r_ptr   <= w_sel;
            r_grant <= w_sel;
        end
    end
    // pass the granted source straight through while locked; idle data is zeroed
    always_comb begin
        s_tready = '0;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        if (r_state == LOCKED) begin
            m_tvalid          = s_tvalid[r_grant];
            m_tdata           = w_slice[r_grant];
            m_tlast           = s_tlast[r_grant];
            s_tready[r_grant] = m_tready;
        end
    end
`ifdef AXIS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_timeout;
    assign w_force     = (r_state == LOCKED) && (r_cnt == CW'(TIMEOUT_CYCLES));
    assign timeout_err = r_timeout;
    // count consecutive locked cycles without a handshake; pulse when the limit forces release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= (r_state != LOCKED || w_hs || w_force) ? '0 : r_cnt + 1'b1;
            r_timeout <= w_force && !(w_hs && m_tlast);
        end
    end
`else
    assign w_force     = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed checks of grant order, packet lock, backpressure, skipping and stall handling
module tb_axis_rr_arbiter;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  s_tvalid;
    logic [63:0] s_tdata;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic        m_tvalid;
    logic [15:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic [1:0]  grant_idx;
    logic        busy;
    logic        timeout_err;
    int total = 0;
    int bad = 0;
    int beat [4];
    int len [4];
    logic [3:0] en;

    axis_rr_arbiter #(.TDATA_WIDTH(16), .NUM_SRC(4), .TIMEOUT_CYCLES(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant_idx(grant_idx), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // source i presents word {i, beat}; tlast on the final beat of its packet
    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i]          = en[i];
            s_tdata[i*16 +: 16]  = 16'(i * 256 + beat[i]);
            s_tlast[i]           = (beat[i] == len[i] - 1);
        end
    endtask

    // finish the cycle: note accepted beats, cross the edge, advance those sources
    task automatic adv();
        logic [3:0] h;
        h = s_tready & s_tvalid;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) if (h[i]) beat[i] = (beat[i] + 1) % len[i];
        drive();
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        aresetn  = 1'b0;
        en       = 4'b0000;
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat[i] = 0;
            len[i]  = 1;
        end
        drive();
        #2;
        chk("async_rst_busy", busy, 1'b0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        // reset values with live source data on the inputs
        aresetn  = 1'b0;
        m_tready = 1'b1;
        en       = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            beat[i] = 0;
            len[i]  = 1;
        end
        drive();
        #12;
        chk("rst_s_tready", s_tready, 4'b0000);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_tdata", m_tdata, 16'h0000);
        chk("rst_m_tlast", m_tlast, 1'b0);
        chk("rst_grant", grant_idx, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        for (int i = 0; i < 4; i++) len[i] = 2;
        drive();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // rotation with 2-beat packets from every source
        @(negedge aclk);
        chk("first_idle_busy", busy, 1'b0);
        chk("first_idle_mvalid", m_tvalid, 1'b0);
        adv();
        for (int c = 0; c < 15; c++) begin
            @(negedge aclk);
            chk("rot_busy", busy, (c % 3) != 2);
            chk("rot_grant", grant_idx, 32'((c / 3) % 4));
            if (c % 3 != 2) begin
                chk("rot_data", m_tdata, 32'(((c / 3) % 4) * 256 + c % 3));
                chk("rot_last", m_tlast, (c % 3) == 1);
            end
            adv();
        end

        // lock held through a valid gap while source 1 keeps requesting
        do_reset();
        len[2] = 4;
        en = 4'b0010;
        drive();
        @(negedge aclk); chk("lk_c0_busy", busy, 1'b0); adv();
        @(negedge aclk); chk("lk_c1_grant", grant_idx, 2'd1); chk("lk_c1_last", m_tlast, 1'b1); adv();
        en = 4'b0110; len[1] = 4; drive();
        @(negedge aclk); chk("lk_c2_busy", busy, 1'b0); adv();
        @(negedge aclk); chk("lk_c3_grant", grant_idx, 2'd2); chk("lk_c3_data", m_tdata, 16'h0200);
        chk("lk_c3_ready", s_tready, 4'b0100); adv();
        @(negedge aclk); chk("lk_c4_data", m_tdata, 16'h0201); chk("lk_c4_ready", s_tready, 4'b0100); adv();
        en[2] = 1'b0; drive();
        @(negedge aclk); chk("lk_c5_mvalid", m_tvalid, 1'b0); chk("lk_c5_ready", s_tready, 4'b0100); adv();
        en[2] = 1'b1; drive();
        @(negedge aclk); chk("lk_c6_data", m_tdata, 16'h0202); chk("lk_c6_last", m_tlast, 1'b0); adv();
        @(negedge aclk); chk("lk_c7_data", m_tdata, 16'h0203); chk("lk_c7_last", m_tlast, 1'b1);
        chk("lk_c7_ready", s_tready, 4'b0100); adv();
        @(negedge aclk); chk("lk_c8_busy", busy, 1'b0); chk("lk_c8_grant", grant_idx, 2'd2);
        chk("lk_c8_ready", s_tready, 4'b0000); adv();
        @(negedge aclk); chk("lk_c9_grant", grant_idx, 2'd1); chk("lk_c9_ready", s_tready, 4'b0010);
        chk("lk_c9_data", m_tdata, 16'h0100);

        // backpressure for 5 cycles on beat 1 of a 4-beat packet
        do_reset();
        len[0] = 4;
        en = 4'b0001;
        drive();
        @(negedge aclk); chk("bp_c0_busy", busy, 1'b0); adv();
        @(negedge aclk); chk("bp_c1_data", m_tdata, 16'h0000); adv();
        m_tready = 1'b0;
        for (int c = 2; c < 7; c++) begin
            @(negedge aclk);
            chk("bp_hold_data", m_tdata, 16'h0001);
            chk("bp_hold_ready", s_tready, 4'b0000);
            chk("bp_hold_mvalid", m_tvalid, 1'b1);
            adv();
        end
        m_tready = 1'b1;
        @(negedge aclk); chk("bp_c7_data", m_tdata, 16'h0001); chk("bp_c7_ready", s_tready, 4'b0001); adv();
        @(negedge aclk); chk("bp_c8_data", m_tdata, 16'h0002); adv();
        @(negedge aclk); chk("bp_c9_data", m_tdata, 16'h0003); chk("bp_c9_last", m_tlast, 1'b1); adv();
        @(negedge aclk); chk("bp_c10_busy", busy, 1'b0);

        // skip idle sources: 0, then only 3, then only 1
        do_reset();
        en = 4'b0001;
        drive();
        @(negedge aclk); chk("sk_c0_busy", busy, 1'b0); adv();
        @(negedge aclk); chk("sk_c1_grant", grant_idx, 2'd0); adv();
        en = 4'b1000; drive();
        @(negedge aclk); chk("sk_c2_busy", busy, 1'b0); adv();
        @(negedge aclk); chk("sk_c3_grant", grant_idx, 2'd3); chk("sk_c3_data", m_tdata, 16'h0300); adv();
        en = 4'b0010; drive();
        @(negedge aclk); chk("sk_c4_busy", busy, 1'b0); adv();
        @(negedge aclk); chk("sk_c5_grant", grant_idx, 2'd1); chk("sk_c5_data", m_tdata, 16'h0100);

        // granted source stalls after its first beat while source 1 waits
        do_reset();
        len[0] = 4;
        en = 4'b0011;
        drive();
        @(negedge aclk); chk("to_c0_busy", busy, 1'b0); adv();
        @(negedge aclk); chk("to_c1_grant", grant_idx, 2'd0); chk("to_c1_data", m_tdata, 16'h0000); adv();
        en[0] = 1'b0; drive();
`ifdef AXIS_ARB_TIMEOUT_EN
        for (int c = 2; c < 11; c++) begin
            @(negedge aclk);
            chk("to_stall_busy", busy, 1'b1);
            chk("to_stall_terr", timeout_err, 1'b0);
            adv();
        end
        @(negedge aclk); chk("to_c11_busy", busy, 1'b0); chk("to_c11_terr", timeout_err, 1'b1); adv();
        @(negedge aclk); chk("to_c12_grant", grant_idx, 2'd1); chk("to_c12_busy", busy, 1'b1);
        chk("to_c12_terr", timeout_err, 1'b0);
`else
        for (int c = 2; c < 14; c++) begin
            @(negedge aclk);
            chk("hold_busy", busy, 1'b1);
            chk("hold_grant", grant_idx, 2'd0);
            chk("hold_terr", timeout_err, 1'b0);
            adv();
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
